// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants for the shift-add multiplier datapath and its control FSM
package mult_pkg;

   localparam int MULT_WIDTH = 32;

   // Counter width able to hold the value w itself (0..w inclusive).
   function automatic int MULT_CW(input int w);
      return $clog2(w) + 1;
   endfunction

   // Select polarity, shared with the control FSM.
   localparam logic SEL_LOAD  = 1'b1;
   localparam logic SEL_SHIFT = 1'b0;

endpackage

// File: rtl/mult_iter_cnt.sv
// rtl/mult_iter_cnt.sv - saturating iteration counter with synchronous clear
module mult_iter_cnt
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CW    = MULT_CW(MULT_WIDTH)
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cont,
   output logic          done
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   // Clear wins; otherwise count up until WIDTH and then hold there.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cont <= '0;
      end else if (clr) begin
         cont <= '0;
      end else if (inc && (cont < LAST)) begin
         cont <= cont + 1'b1;
      end
   end

   assign done = (cont == LAST);

endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - shift-add multiplier datapath: operand, product and iteration registers
module mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CW    = MULT_CW(MULT_WIDTH)
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [WIDTH-1:0]   A_in,
   input  logic [WIDTH-1:0]   B_in,
   input  logic               a_sel,
   input  logic               b_sel,
   input  logic               prod_sel,
   input  logic               add_sel,
   output logic               b_lsb,
   output logic [CW-1:0]      cont,
   output logic [2*WIDTH-1:0] Product,
   output logic               done
);

   logic [2*WIDTH-1:0] A_reg;
   logic [WIDTH-1:0]   B_reg;
   logic [2*WIDTH-1:0] P_reg;
   logic               running;
   logic               stepping;

   // Frozen once the count reaches WIDTH; a step is any running cycle without a B load.
   assign running  = !done;
   assign stepping = running && (b_sel == SEL_SHIFT);

   mult_iter_cnt #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_cnt (
      .Clock (Clock),
      .Reset (Reset),
      .clr   (b_sel == SEL_LOAD),
      .inc   (1'b1),
      .cont  (cont),
      .done  (done)
   );

   // Multiplicand: zero-extended load, or one left shift per step.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         A_reg <= '0;
      end else if (a_sel == SEL_LOAD) begin
         A_reg <= {{WIDTH{1'b0}}, A_in};
      end else if (stepping) begin
         A_reg <= {A_reg[2*WIDTH-2:0], 1'b0};
      end
   end

   // Multiplier: load, or shift right while running so b_lsb presents the next bit.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         B_reg <= '0;
      end else if (b_sel == SEL_LOAD) begin
         B_reg <= B_in;
      end else if (running) begin
         B_reg <= {1'b0, B_reg[WIDTH-1:1]};
      end
   end

   // Partial product: clear has priority; add uses the pre-shift multiplicand and wraps.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         P_reg <= '0;
      end else if (prod_sel == SEL_LOAD) begin
         P_reg <= '0;
      end else if (stepping && add_sel) begin
         P_reg <= P_reg + A_reg;
      end
   end

   assign b_lsb   = B_reg[0];
   assign Product = P_reg;

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - self-checking bench for mult_datapath
module tb_mult_datapath;
   import mult_pkg::*;

   localparam int W  = MULT_WIDTH;
   localparam int CW = MULT_CW(MULT_WIDTH);

   logic           Clock;
   logic           Reset;
   logic [W-1:0]   A_in;
   logic [W-1:0]   B_in;
   logic           a_sel;
   logic           b_sel;
   logic           prod_sel;
   logic           add_sel;
   logic           b_lsb;
   logic [CW-1:0]  cont;
   logic [2*W-1:0] Product;
   logic           done;

   int n_pass;
   int n_total;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } vec_t;

   vec_t vecs[6];

   mult_datapath #(.WIDTH(W), .CW(CW)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .A_in     (A_in),
      .B_in     (B_in),
      .a_sel    (a_sel),
      .b_sel    (b_sel),
      .prod_sel (prod_sel),
      .add_sel  (add_sel),
      .b_lsb    (b_lsb),
      .cont     (cont),
      .Product  (Product),
      .done     (done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
      A_in = a; B_in = b;
      a_sel = 1'b1; b_sel = 1'b1; prod_sel = 1'b1; add_sel = 1'b0;
      @(posedge Clock); #1;
      a_sel = 1'b0; b_sel = 1'b0; prod_sel = 1'b0;
   endtask

   // One step with add_sel following b_lsb, as the FSM does.
   task automatic step_canon();
      add_sel = b_lsb;
      @(posedge Clock); #1;
   endtask

   task automatic step_with(input logic add);
      add_sel = add;
      @(posedge Clock); #1;
   endtask

   task automatic run_canon(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp, input string tag);
      load(a, b);
      chk({tag, " cont after load"}, 64'(cont), 64'd0);
      for (int i = 0; i < W - 1; i++) step_canon();
      chk({tag, " done before last step"}, 64'(done), 64'd0);
      chk({tag, " cont before last step"}, 64'(cont), 64'(W - 1));
      step_canon();
      chk({tag, " done"}, 64'(done), 64'd1);
      chk({tag, " cont"}, 64'(cont), 64'(W));
      chk({tag, " product"}, Product, exp);
   endtask

   logic [W-1:0]   ra, rb;
   logic [2*W-1:0] rexp, hold_p;
   logic           hold_lsb, rnd;

   initial begin
      n_pass = 0; n_total = 0;
      A_in = '0; B_in = '0;
      a_sel = 1'b0; b_sel = 1'b0; prod_sel = 1'b0; add_sel = 1'b0;
      Reset = 1'b0;
      #12;
      chk("reset cont", 64'(cont), 64'd0);
      chk("reset product", Product, 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset b_lsb", 64'(b_lsb), 64'd0);
      @(posedge Clock); #1;
      Reset = 1'b1;

      vecs[0] = '{a: 32'd3,          b: 32'd5,          p: 64'd15};
      vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   p: 64'hFFFFFFFE00000001};
      vecs[2] = '{a: 32'd0,          b: 32'hDEADBEEF,   p: 64'd0};
      vecs[3] = '{a: 32'd7,          b: 32'd6,          p: 64'd42};
      vecs[4] = '{a: 32'd1,          b: 32'hFFFFFFFF,   p: 64'h00000000FFFFFFFF};
      vecs[5] = '{a: 32'h80000000,   b: 32'd2,          p: 64'h0000000100000000};
      for (int v = 0; v < 6; v++) run_canon(vecs[v].a, vecs[v].b, vecs[v].p, $sformatf("vec%0d", v));

      // Freeze: after done, add requests and non-load cycles change nothing.
      hold_p = Product; hold_lsb = b_lsb;
      for (int i = 0; i < 10; i++) step_with(1'b1);
      chk("freeze product", Product, hold_p);
      chk("freeze cont", 64'(cont), 64'(W));
      chk("freeze b_lsb", 64'(b_lsb), 64'(hold_lsb));
      chk("freeze done", 64'(done), 64'd1);

      // Asynchronous reset mid-run, between edges.
      load(32'h1234, 32'hFFFF);
      for (int i = 0; i < 10; i++) step_canon();
      chk("pre-reset cont", 64'(cont), 64'd10);
      #2 Reset = 1'b0;
      #1;
      chk("async reset cont", 64'(cont), 64'd0);
      chk("async reset product", Product, 64'd0);
      chk("async reset done", 64'(done), 64'd0);
      @(posedge Clock); #1;
      Reset = 1'b1;

      // Reload mid-operation.
      load(32'h12345, 32'hFF);
      for (int i = 0; i < 10; i++) step_canon();
      chk("reload pre cont", 64'(cont), 64'd10);
      run_canon(32'd7, 32'd6, 64'd42, "reload");

      // Clear priority over add in a step cycle; B and cont keep moving.
      load(32'd5, 32'd13);
      step_with(1'b1);
      chk("pclr first add", Product, 64'd5);
      prod_sel = 1'b1;
      step_with(1'b1);
      prod_sel = 1'b0;
      chk("pclr product", Product, 64'd0);
      chk("pclr cont", 64'(cont), 64'd2);
      chk("pclr b_lsb", 64'(b_lsb), 64'd1);

      // Randomized: canonical runs check A*B; free-add runs check the sum of shifted A terms.
      for (int t = 0; t < 24; t++) begin
         ra = $urandom; rb = $urandom;
         if (t % 2 == 0) begin
            rexp = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            run_canon(ra, rb, rexp, $sformatf("rnd%0d", t));
         end else begin
            load(ra, rb);
            rexp = '0;
            for (int i = 0; i < W; i++) begin
               rnd = 1'($urandom_range(0, 1));
               if (rnd) rexp = rexp + ({{W{1'b0}}, ra} << i);
               step_with(rnd);
            end
            // Extra requested adds past the end must be ignored.
            step_with(1'b1);
            chk($sformatf("rndadd%0d product", t), Product, rexp);
            chk($sformatf("rndadd%0d cont", t), 64'(cont), 64'(W));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, expected finish before 500000");
      $fatal(1);
   end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Shift-add multiplier datapath driven by the multiplier control FSM. Holds the multiplicand, multiplier and partial-product registers plus the iteration counter, and performs one shift/conditional-add step per cycle under the FSM's select lines. Returns `b_lsb` and `cont` to the FSM so it can decide add/no-add and termination. Presents the final `2*WIDTH`-bit product with a `done` flag.

## Interface
- `WIDTH`, 32: operand width in bits.
- `CW`, `$clog2(WIDTH)+1`: counter width; must be able to hold the value `WIDTH`.

Ports:
- `Clock`  in  1  single clock; all registers update on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `A_in`  in  WIDTH  multiplicand operand.
- `B_in`  in  WIDTH  multiplier operand.
- `a_sel`  in  1  1 = load A from `A_in`; 0 = shift A left.
- `b_sel`  in  1  1 = load B from `B_in` and clear `cont`; 0 = shift B right and count.
- `prod_sel`  in  1  1 = clear product.
- `add_sel`  in  1  1 = add A into product this step.
- `b_lsb`  out  1  `B_reg[0]`.
- `cont`  out  CW  completed iteration count, 0..WIDTH.
- `Product`  out  2*WIDTH  product register.
- `done`  out  1  `cont == WIDTH`.

## Operation
- Internal registers:
  - `A_reg`: 2*WIDTH bits, `A_in` zero-extended on load.
  - `B_reg`: WIDTH bits.
  - `P_reg`: 2*WIDTH bits, drives `Product`.
  - `cont`: CW bits.
- Running: `cont < WIDTH`. Frozen: `cont == WIDTH`.
- The selects act independently per register.
  - `A_reg`:
    - `a_sel=1` loads.
    - Else, if running and `b_sel=0`, it shifts left by 1 with 0 fill.
    - Else it holds.
  - `B_reg` and `cont`:
    - `b_sel=1` loads `B_reg` and sets `cont=0`.
    - Else, if running, `B_reg` shifts right by 1 with 0 fill and `cont` increments.
    - Else both hold.
  - `P_reg`:
    - `prod_sel=1` clears it to 0. This has priority over `add_sel`.
    - Else, if running, `b_sel=0` and `add_sel=1`, it becomes `P_reg + A_reg`. The add uses pre-shift `A_reg`, is 2*WIDTH bits wide, and wraps mod 2^(2*WIDTH). It cannot overflow for valid operands.
    - Else it holds.
- Canonical sequence:
  - One load cycle with `a_sel=b_sel=prod_sel=1`.
  - Then WIDTH step cycles with all three selects at 0 and `add_sel=b_lsb`.
- While frozen, shifts, adds and counting are all suppressed. `Product` and `done` hold until the next load, regardless of `add_sel`.
- `cont` saturates at WIDTH and never wraps.
- Reload mid-operation (`b_sel=1` while running): `cont` returns to 0 and the new operands are taken. `P_reg` clears only if `prod_sel=1` in the same cycle.
- `Reset` low asserts asynchronously at any time:
  - All registers go to 0: `b_lsb=0`, `cont=0`, `Product=0`, `done=0`.
  - The block leaves reset in the running state with B=0.

## Timing
- `b_lsb`, `cont`, `done` and `Product` are pure register outputs or decodes of registers, with no combinational path from inputs.
- Load on edge 0, steps on edges 1..WIDTH.
- `done` rises after edge WIDTH, i.e. WIDTH+1 cycles after the load cycle. `Product` is final in that same cycle.
- `b_lsb` seen in a step cycle reflects the bit consumed at that cycle's edge. The FSM drives `add_sel` combinationally from it in the same cycle.
- `done` is stable from rising until the next `b_sel=1` edge or reset.

## Structure
- Shared package `mult_pkg`:
  - `MULT_WIDTH` = 32.
  - `MULT_CW` function/constant.
  - Select-polarity constants (`SEL_LOAD=1`, `SEL_SHIFT=0`), shared with the FSM.
- One sub-module is natural: `mult_iter_cnt`, a saturating CW-bit counter with synchronous clear and `Reset`. It exposes `cont` and `done`.
- All other logic stays in `mult_datapath`.

## Test plan
- Reset mid-run: drive `Reset` low at `cont=10`, asynchronously between edges → `cont=0`, `Product=0`, `done=0` immediately, before the next edge.
- 3 × 5 (WIDTH=32): load, then 32 steps with `add_sel=b_lsb` → `Product=15`, `done=1` exactly after edge 32, `cont=32`.
- 0xFFFFFFFF × 0xFFFFFFFF → `Product=0xFFFFFFFE00000001`; also 0 × 0xDEADBEEF → 0.
- Freeze: after `done`, hold `add_sel=1` and `b_sel=0` for 10 cycles → `Product`, `cont=32` and `b_lsb` unchanged.
- Reload at `cont=10` with `A_in=7`, `B_in=6`, all loads set → `cont=0`, `P=0`; after 32 steps, `Product=42`.
- `prod_sel=1` with `add_sel=1` in a step cycle → `P_reg=0` after the edge, while B still shifts and `cont` still increments.
